// File: rtl/sig_capture.sv
// rtl/sig_capture.sv - Signature store capture FIFO with halt detection, watchdog and drain FSM.
// Stores to SIG_ADDR are queued for a consumer; a halt store or watchdog expiry ends capture.
module sig_capture #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] SIG_ADDR  = 32'h00000F00,
  parameter logic [31:0] HALT_ADDR = 32'hCAFEBEEF,
  parameter int          TIMEOUT   = 5000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  output logic                     sig_valid,
  output logic [31:0]              sig_data,
  input  logic                     sig_ready,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  output logic                     timeout,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state, state_next;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [FW-1:0]   fill_next;
  logic [WW-1:0]   wdog;
  logic            is_sig, is_halt, full, pop;
  logic            push, drop, expire;

  assign is_sig  = st_valid && (st_addr == SIG_ADDR);
  assign is_halt = st_valid && (st_addr == HALT_ADDR);
  assign full    = (fill == FW'(DEPTH));

  // Output is masked during reset and whenever empty so stale memory never leaks out.
  assign sig_valid = (fill != '0) && !rst;
  assign sig_data  = sig_valid ? mem[rd_ptr] : 32'h0;
  assign pop       = sig_valid && sig_ready;
  assign fill_next = fill + FW'(push) - FW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    drop       = 1'b0;
    expire     = 1'b0;
    done       = 1'b0;
    case (state)
      S_RUN: begin
        if (is_sig) begin
          if (!full || pop) push = 1'b1;
          else              drop = 1'b1;
        end
        // A halt in the expiry cycle takes precedence over the watchdog.
        if (is_halt) begin
          state_next = S_DRAIN;
        end else if (wdog == WW'(TIMEOUT - 1)) begin
          expire     = 1'b1;
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((fill == '0) || ((fill == FW'(1)) && pop)) state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fill     <= '0;
      wdog     <= '0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fill <= fill_next;
      if (state == S_RUN) wdog <= wdog + WW'(1);
      if (drop)   overflow <= 1'b1;
      if (expire) timeout  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= st_data;
  end

endmodule

// File: tb/tb_sig_capture.sv
// tb/tb_sig_capture.sv - Directed self-checking bench for sig_capture.
module tb_sig_capture;

  localparam int          DEPTH     = 8;
  localparam int          TIMEOUT   = 40;
  localparam logic [31:0] SIG_ADDR  = 32'h00000F00;
  localparam logic [31:0] HALT_ADDR = 32'hCAFEBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        sig_valid;
  logic [31:0] sig_data;
  logic        sig_ready;
  logic [$clog2(DEPTH):0] fill;
  logic        overflow;
  logic        timeout;
  logic        done;

  int checks = 0;
  int errors = 0;

  sig_capture #(
    .DEPTH(DEPTH), .SIG_ADDR(SIG_ADDR), .HALT_ADDR(HALT_ADDR), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .sig_valid(sig_valid), .sig_data(sig_data), .sig_ready(sig_ready), .fill(fill),
    .overflow(overflow), .timeout(timeout), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; sig_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_addr = a; st_data = d;
    tick();
    st_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_fill", 32'(fill), 0);
    chk("rst_valid", 32'(sig_valid), 0);
    chk("rst_data", sig_data, 32'h0);
    chk("rst_flags", {29'b0, overflow, timeout, done}, 0);

    // streaming with consumer always ready
    sig_ready = 1'b1;
    store(SIG_ADDR, 32'd11);
    chk("s1_data", sig_data, 32'd11);
    chk("s1_fill", 32'(fill), 1);
    store(SIG_ADDR, 32'd22);
    chk("s2_data", sig_data, 32'd22);
    chk("s2_fill", 32'(fill), 1);
    store(SIG_ADDR, 32'd33);
    chk("s3_data", sig_data, 32'd33);
    chk("s3_valid", 32'(sig_valid), 1);
    store(32'h00000F04, 32'd44);
    chk("other_addr_fill", 32'(fill), 0);
    chk("other_addr_valid", 32'(sig_valid), 0);

    // overflow: DEPTH+1 stores with stalled consumer
    do_reset();
    for (int i = 0; i <= DEPTH; i++) store(SIG_ADDR, 32'hA0 + 32'(i));
    chk("ovf_fill", 32'(fill), DEPTH);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_hold", sig_data, 32'hA0);
    tick();
    chk("ovf_hold2", sig_data, 32'hA0);
    sig_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_drain", sig_data, 32'hA0 + 32'(i));
      tick();
    end
    chk("ovf_empty", 32'(sig_valid), 0);

    // push into full FIFO with same-cycle pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) store(SIG_ADDR, 32'hB0 + 32'(i));
    sig_ready = 1'b1;
    store(SIG_ADDR, 32'hB0 + 32'(DEPTH));
    chk("fullpop_fill", 32'(fill), DEPTH);
    chk("fullpop_ovf", 32'(overflow), 0);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("fullpop_drain", sig_data, 32'hB0 + 32'(i));
      tick();
    end
    chk("fullpop_empty", 32'(fill), 0);

    // halt then trailing store, drain to done
    do_reset();
    for (int i = 0; i < 5; i++) store(SIG_ADDR, 32'hC0 + 32'(i));
    store(HALT_ADDR, 32'h12345678);
    store(SIG_ADDR, 32'hDEAD);
    chk("halt_fill", 32'(fill), 5);
    chk("halt_done0", 32'(done), 0);
    sig_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("halt_drain", sig_data, 32'hC0 + 32'(i));
      chk("halt_notdone", 32'(done), 0);
      tick();
    end
    chk("halt_done", 32'(done), 1);
    chk("halt_empty", 32'(sig_valid), 0);
    store(SIG_ADDR, 32'hBEEF);
    chk("done_ignore", 32'(fill), 0);
    chk("done_sticky", 32'(done), 1);
    chk("halt_no_to", 32'(timeout), 0);

    // watchdog expiry with nothing queued
    do_reset();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("wd_pre", 32'(timeout), 0);
    tick();
    chk("wd_to", 32'(timeout), 1);
    chk("wd_drain_notdone", 32'(done), 0);
    tick();
    chk("wd_done", 32'(done), 1);

    // halt coinciding with expiry
    do_reset();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    store(HALT_ADDR, 32'h0);
    chk("wdhalt_to", 32'(timeout), 0);
    tick();
    chk("wdhalt_done", 32'(done), 1);
    chk("wdhalt_to2", 32'(timeout), 0);

    // reset mid-drain
    do_reset();
    for (int i = 0; i <= DEPTH; i++) store(SIG_ADDR, 32'hD0 + 32'(i));
    store(HALT_ADDR, 32'h0);
    sig_ready = 1'b1;
    for (int i = 0; i < DEPTH - 3; i++) tick();
    sig_ready = 1'b0;
    chk("mid_fill", 32'(fill), 3);
    chk("mid_ovf", 32'(overflow), 1);
    chk("mid_data", sig_data, 32'hD0 + 32'(DEPTH - 3));
    rst = 1'b1;
    #1;
    chk("rsthi_valid", 32'(sig_valid), 0);
    tick();
    rst = 1'b0;
    chk("mid_rst_fill", 32'(fill), 0);
    chk("mid_rst_valid", 32'(sig_valid), 0);
    chk("mid_rst_flags", {29'b0, overflow, timeout, done}, 0);
    store(SIG_ADDR, 32'h77);
    chk("mid_rst_run", 32'(fill), 1);
    chk("mid_rst_data", sig_data, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sig_capture.md
SIG_CAPTURE -- requirements
Module: sig_capture

Interface
REQ-001 Parameter DEPTH, default 16, is the signature FIFO depth in words and SHALL be a power of two ≥2.
REQ-002 Parameter SIG_ADDR, default 32'h00000F00, is the signature store address.
REQ-003 Parameter HALT_ADDR, default 32'hCAFEBEEF, is the halt store address.
REQ-004 Parameter TIMEOUT, default 5000, is the watchdog limit in cycles.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 st_valid  input  1  a store is being committed from the writeback path this cycle.
REQ-008 st_addr  input  32  store address (ALU result at writeback).
REQ-009 st_data  input  32  store data.
REQ-010 sig_valid  output  1  sig_data holds an undrained signature word.
REQ-011 sig_data  output  32  head-of-FIFO signature word.
REQ-012 sig_ready  input  1  consumer accepts sig_data when sig_valid is also high.
REQ-013 fill  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 overflow  output  1  sticky; a signature store was dropped.
REQ-015 timeout  output  1  sticky; watchdog expired before halt.
REQ-016 done  output  1  capture finished and FIFO drained.

Function
REQ-017 FSM states SHALL be RUN, DRAIN, and DONE; reset enters RUN.
REQ-018 In RUN, st_valid with st_addr==SIG_ADDR SHALL push st_data when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-019 A push to a full FIFO without a same-cycle pop SHALL drop the word and set overflow; FIFO contents SHALL remain unchanged.
REQ-020 Pop SHALL occur when sig_valid && sig_ready; sig_valid SHALL equal (fill!=0) in every state.
REQ-021 Push-to-visible latency SHALL be 1 cycle: a word pushed at edge N SHALL appear on sig_data/sig_valid after edge N when the FIFO was empty.
REQ-022 sig_data SHALL hold steady while sig_valid is high and sig_ready is low.
REQ-023 The FIFO SHALL preserve push order; read and write pointers SHALL wrap modulo DEPTH.
REQ-024 fill SHALL update as +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
REQ-025 In RUN, st_valid with st_addr==HALT_ADDR SHALL transition to DRAIN on the next edge; st_data SHALL be ignored.
REQ-026 Stores to any other address SHALL be ignored.
REQ-027 The watchdog counter SHALL increment every cycle in RUN; reaching TIMEOUT−1 without a halt SHALL set timeout and transition to DRAIN.
REQ-028 If a halt store and watchdog expiry coincide, the halt SHALL win and timeout SHALL remain 0.
REQ-029 In DRAIN and DONE, all stores SHALL be ignored, including signature stores and further halts.
REQ-030 In DRAIN, the FSM SHALL move to DONE on the edge where fill becomes 0, or immediately on the next edge if fill is already 0.
REQ-031 DONE SHALL be terminal until reset; done SHALL be high only in DONE.
REQ-032 overflow and timeout SHALL be cleared only by reset.

Reset
REQ-033 rst high at an edge SHALL, in any state and including mid-drain, force RUN and clear the pointers, fill, watchdog, overflow, timeout, and done.
REQ-034 While rst is high, sig_valid SHALL be 0 and all stores SHALL be ignored.
REQ-035 After reset, sig_data SHALL be 32'h0.

Verification
REQ-036 Three SIG_ADDR stores (11,22,33) with sig_ready=1 -> sig_data 11,22,33 on consecutive cycles, each appearing 1 cycle after its store; fill ≤1.
REQ-037 DEPTH+1 SIG_ADDR stores with sig_ready=0 -> fill==DEPTH, overflow=1, and the drain returns only the first DEPTH words.
REQ-038 Store to SIG_ADDR into a full FIFO while sig_ready=1 -> no overflow, fill stays DEPTH, and the new word is drained last.
REQ-039 Five words queued, then a HALT_ADDR store, then a SIG_ADDR store -> the trailing store is ignored; done rises on the cycle after the fifth pop.
REQ-040 No halt for TIMEOUT cycles -> timeout=1 and done=1 once empty; a halt at the expiry cycle -> timeout=0.
REQ-041 rst pulsed during DRAIN with fill=3 -> next cycle fill=0, sig_valid=0, state RUN, and all flags 0.
